// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: minimum-hold round-robin owner of HEX5..HEX0 between requesters A and B, plus display tick; define HEXARB_BLANK_EN for a blank gap on owner swaps
module hex_display_arbiter #(
  parameter int TICK_DIV   = 10000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_a,
  input  logic [47:0] pat_a,
  input  logic        req_b,
  input  logic [47:0] pat_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic        tick,
  output logic [7:0]  HEX0,
  output logic [7:0]  HEX1,
  output logic [7:0]  HEX2,
  output logic [7:0]  HEX3,
  output logic [7:0]  HEX4,
  output logic [7:0]  HEX5
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  typedef enum logic [1:0] {
    IDLE, OWN_A, OWN_B
`ifdef HEXARB_BLANK_EN
    , BLANK
`endif
  } state_t;
  state_t state_q, state_d, direct;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic ga_q, ga_d, gb_q, gb_d, own, hold_max;
  logic [47:0] hex_q, hex_d;
`ifdef HEXARB_BLANK_EN
  logic tgt_b_q, tgt_b_d;
`endif
  assign tick = cnt_q == CW'(TICK_DIV - 1);
  assign own = state_q == OWN_A || state_q == OWN_B;
  assign hold_max = hold_q == HW'(HOLD_TICKS);
  assign grant_a = ga_q;
  assign grant_b = gb_q;
  assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = hex_q;
  // Ownership decision, hold accounting and the registered output image of the next state
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    case (state_q)
      IDLE:    direct = req_a ? OWN_A : (req_b ? OWN_B : IDLE);
      OWN_A:   direct = !req_a ? (req_b ? OWN_B : IDLE) : ((req_b && hold_max) ? OWN_B : OWN_A);
      OWN_B:   direct = !req_b ? (req_a ? OWN_A : IDLE) : ((req_a && hold_max) ? OWN_A : OWN_B);
      default: direct = IDLE;
    endcase
    state_d = direct;
`ifdef HEXARB_BLANK_EN
    tgt_b_d = tgt_b_q;
    if (state_q == BLANK)
      state_d = !tick ? BLANK
              : tgt_b_q ? (req_b ? OWN_B : (req_a ? OWN_A : IDLE))
              : (req_a ? OWN_A : (req_b ? OWN_B : IDLE));
    else if (own && direct != IDLE && direct != state_q) begin
      state_d = BLANK;
      tgt_b_d = direct == OWN_B;
    end
`endif
    hold_d = !(own && state_d == state_q) ? '0 : (tick && !hold_max) ? hold_q + HW'(1) : hold_q;
    ga_d = state_d == OWN_A;
    gb_d = state_d == OWN_B;
    hex_d = ga_d ? pat_a : (gb_d ? pat_b : '1);
  end
  // State, counters and output registers with asynchronous clear to the blank idle display
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      hold_q <= '0;
      ga_q <= 1'b0;
      gb_q <= 1'b0;
      hex_q <= '1;
`ifdef HEXARB_BLANK_EN
      tgt_b_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      ga_q <= ga_d;
      gb_q <= gb_d;
      hex_q <= hex_d;
`ifdef HEXARB_BLANK_EN
      tgt_b_q <= tgt_b_d;
`endif
    end
  end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: scoreboard bench against an owner/tick reference model
module tb_hex_display_arbiter;
  localparam int TD = 4;
  localparam int HT = 2;
  logic clock = 0, resetn = 0, req_a = 0, req_b = 0;
  logic [47:0] pat_a = '0, pat_b = '0;
  logic grant_a, grant_b, tick;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  typedef struct packed {logic ga; logic gb; logic t; logic [47:0] hex;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  int cyc = 0, owner = 0, held = 0;
  logic ra, rb;
  logic [47:0] pa, pb;
  wire [47:0] hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  hex_display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .clock(clock), .resetn(resetn), .req_a(req_a), .pat_a(pat_a), .req_b(req_b), .pat_b(pat_b),
    .grant_a(grant_a), .grant_b(grant_b), .tick(tick),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5));

  always #5 clock = ~clock;

  function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Owner model: 0 none, 1 A, 2 B; held counts ticks spent owning, capped at HT
  task automatic step(input logic sa, input logic [47:0] spa, input logic sb, input logic [47:0] spb);
    logic tk;
    int nxt;
    exp_t e;
    req_a = sa; pat_a = spa; req_b = sb; pat_b = spb;
    tk = (cyc % TD) == TD - 1;
    nxt = owner;
    if (owner == 0) nxt = sa ? 1 : (sb ? 2 : 0);
    else begin
      logic mine, other;
      mine = (owner == 1) ? sa : sb;
      other = (owner == 1) ? sb : sa;
      if (!mine) nxt = other ? 3 - owner : 0;
      else if (other && held == HT) nxt = 3 - owner;
    end
    if (nxt == owner && nxt != 0) held = (held + int'(tk) > HT) ? HT : held + int'(tk);
    else held = 0;
    owner = nxt;
    cyc++;
    e.ga = owner == 1;
    e.gb = owner == 2;
    e.t = (cyc % TD) == TD - 1;
    e.hex = (owner == 1) ? spa : ((owner == 2) ? spb : {48{1'b1}});
    q.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grants", {46'd0, grant_a, grant_b}, {46'd0, e.ga, e.gb});
        chk("hex", hex_all, e.hex);
        chk("tick", {47'd0, tick}, {47'd0, e.t});
      end
    end
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_grants", {46'd0, grant_a, grant_b}, 48'd0);
    chk("reset_hex", hex_all, {48{1'b1}});
    chk("reset_tick", {47'd0, tick}, 48'd0);
    resetn = 1;
    repeat (9) step(0, '0, 0, '0);
    pa = 48'h8AC0FF80C18E;
    repeat (3) step(1, pa, 0, '0);
    step(1, 48'h123456789ABC, 0, '0);
    repeat (2) step(0, pa, 0, '0);
    pb = 48'hF9A4B0999282;
    repeat (20) step(1, pa, 1, pb);
    repeat (2) step(0, pa, 0, pb);
    while ((cyc % TD) != TD - 1) step(1, pa, 0, pb);
    step(0, pa, 1, pb);
    repeat (3) step(0, pa, 1, pb);
    @(posedge clock);
    #3;
    resetn = 0;
    #1;
    chk("async_grants", {46'd0, grant_a, grant_b}, 48'd0);
    chk("async_hex", hex_all, {48{1'b1}});
    chk("async_tick", {47'd0, tick}, 48'd0);
    q.delete();
    owner = 0; held = 0; cyc = 0;
    repeat (2) @(negedge clock);
    resetn = 1;
    repeat (6) step(0, '0, 1, pb);
    ra = 0; rb = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) ra = !ra;
      if ($urandom_range(5) == 0) rb = !rb;
      step(ra, 48'({$urandom(), $urandom()}), rb, 48'({$urandom(), $urandom()}));
    end
    @(posedge clock);
    #2;
    chk("queue_drained", 48'(q.size()), 48'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the six active-low seven-segment digits (HEX5..HEX0) between two pattern sources: requester A (high priority, e.g. reaction-time readout) and requester B (e.g. scrolling marquee). It grants ownership with a minimum-hold round-robin policy. It also generates the common display step tick that sources use to advance their patterns. It sits between the pattern generators and the board HEX pins.

## Interface
- TICK_DIV, 10000000, clock cycles per display tick; must be ≥ 2.
- HOLD_TICKS, 4, minimum ticks an owner keeps the display before a waiting requester can take it; must be ≥ 1.

- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_a  in  1  requester A wants the display (level).
- pat_a  in  48  A's pattern, {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0}, 8 bits per digit, bit7 = DP, active-low segments.
- req_b  in  1  requester B wants the display (level).
- pat_b  in  48  B's pattern, same packing.
- grant_a  out  1  A owns the display (registered).
- grant_b  out  1  B owns the display (registered).
- tick  out  1  one-cycle pulse every TICK_DIV clocks.
- HEX0..HEX5  out  8 each  registered digit drives; 8'hFF = blank.

## Operation
- Tick counter, width $clog2(TICK_DIV): counts 0..TICK_DIV-1, then wraps to 0. tick = (counter == TICK_DIV-1), decoded from the counter register. The counter runs continuously regardless of state.
- States:
  - IDLE: no grant, all HEX = 8'hFF.
  - OWN_A: grant_a = 1.
  - OWN_B: grant_b = 1.
  - BLANK: only with macro, see Configuration.
- hold_cnt: increments on each tick while in OWN_x and staying there, saturating at HOLD_TICKS. It clears on every state change.
- Transitions, evaluated every clock:
  - IDLE: req_a → OWN_A; else req_b → OWN_B; else stay.
  - OWN_A:
    - !req_a → OWN_B if req_b, else IDLE.
    - req_a && req_b && hold_cnt == HOLD_TICKS → OWN_B.
    - Otherwise stay.
  - OWN_B: symmetric to OWN_A, with A as the waiting requester.
- Release beats fairness: when the owner drops its request, the switch happens at once, independent of hold_cnt and tick.
- Both requests rising together in IDLE: A wins.
- HEX outputs and grants are registered from the next state on the same edge:
  - next state OWN_A: HEX5..HEX0 ← pat_a[47:0] slices.
  - next state OWN_B: HEX5..HEX0 ← pat_b slices.
  - otherwise: all 8'hFF.
  - While an owner stays granted, HEX re-samples its pattern every clock.
- Reset values: state IDLE, counter 0, hold_cnt 0, grant_a = grant_b = 0, tick = 0, HEX0..HEX5 = 8'hFF.
- Assertion of resetn mid-operation forces reset values immediately, asynchronously. After release, the first tick occurs TICK_DIV-1 cycles later.

## Timing
- Request to grant: req sampled high at edge n in IDLE → grant and owner pattern visible after edge n, i.e. 1-cycle latency.
- Owner pattern change to HEX: 1 cycle.
- Owner drop to switch: 1 cycle. The old grant and new grant never overlap, and a grant never goes high in the same cycle as the other grant is low-to-high with no owner in between.
- Fair preemption: hold_cnt saturates at the edge where tick = 1. The switch occurs at the following edge, if the other requester is still asserting.
- No combinational path from req_*/pat_* to any output.

## Configuration
- HEXARB_BLANK_EN defined:
  - Every direct OWN_A↔OWN_B transition, whether by release or preemption, instead enters BLANK and latches the target owner.
  - BLANK drives all HEX = 8'hFF with both grants low, and stays until a tick edge.
  - At that tick: target req high → target; else other req high → other; else IDLE.
  - Reset in BLANK returns to IDLE.
- HEXARB_BLANK_EN undefined: BLANK state does not exist; switches are direct as above.

## Test plan
- Use TICK_DIV = 4, HOLD_TICKS = 2 for all scenarios.
- Reset released, no requests → tick high every 4th cycle (first at cycle 3), HEX all 8'hFF, both grants 0.
- req_a = 1 with pat_a = 48'h8AC0FF80C18E → grant_a = 1 and HEX5..HEX0 = 8A,C0,FF,80,C1,8E one cycle later. Then req_a = 0 → IDLE and all 8'hFF one cycle later.
- req_a and req_b rise together → A granted. After 2 ticks (hold_cnt = 2), grant_b = 1 on the next edge with pat_b shown. After 2 more ticks, ownership returns to A.
- Owner A drops req_a in the same cycle as tick while B is waiting → grant_b at the next edge, independent of hold_cnt.
- resetn pulsed low while OWN_B → grants 0 and HEX 8'hFF without waiting for a clock edge; counter restarts.
- With HEXARB_BLANK_EN: an A→B preemption shows all 8'hFF with both grants 0 until the next tick edge, then grant_b = 1. If req_b drops during BLANK and req_a is high → return to OWN_A.
